// File: rtl/aes_pkg.sv
// Shared AES types and constants for the AddRoundKey pipeline stage.
package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [3:0]   round_t;

   localparam int unsigned AES_NR_128 = 10;
   localparam int unsigned AES_NR_192 = 12;
   localparam int unsigned AES_NR_256 = 14;

   typedef struct packed {
      state_t data;
      round_t rnd;
      logic   last;
   } ark_beat_t;

   localparam int unsigned ARK_PAYLOAD_W = $bits(ark_beat_t);

   // A new block restarts at 1; a previous final round also wraps to 1.
   function automatic round_t next_round(round_t prev, logic first, round_t nr);
      if (first || prev == nr) begin
         return round_t'(1);
      end
      return prev + round_t'(1);
   endfunction

endpackage

// File: rtl/ark_skid.sv
// Output register plus one skid entry; in_ready_o is a registered flag, never fed by out_ready_i.
module ark_skid #(
   parameter int unsigned Width = 133
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);

   logic             out_valid_q;
   logic             skid_valid_q;
   logic [Width-1:0] out_q;
   logic [Width-1:0] skid_q;

   assign in_ready_o  = rst_ni & ~skid_valid_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else if (!out_valid_q || out_ready_i) begin
         // Output slot frees up: the parked beat goes first to keep ordering.
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_q        <= skid_q;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q <= in_valid_i;
            if (in_valid_i) begin
               out_q <= in_data_i;
            end
         end
      end else if (in_valid_i && !skid_valid_q) begin
         skid_q       <= in_data_i;
         skid_valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage with round tracking; define ARK_SKID_EN to add a 1-entry skid buffer
// that registers in_ready.
module add_round_key_stage
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR_128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_first,
   input  logic [127:0] mix_data,
   input  logic [127:0] sr_data,
   input  logic [127:0] round_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [3:0]   out_round,
   output logic         out_last
);

   localparam round_t NrR = round_t'(NR);

   round_t    rnd_q;
   round_t    rnd_d;
   ark_beat_t beat;
   ark_beat_t out_beat;
   logic      in_xfer;

   assign in_xfer = in_valid && in_ready;

   always_comb begin
      rnd_d     = next_round(rnd_q, in_first, NrR);
      beat.rnd  = rnd_d;
      beat.last = (rnd_d == NrR);
      // The final round skips MixColumns, so ShiftRows output feeds the key XOR.
      beat.data = (beat.last ? sr_data : mix_data) ^ round_key;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_q <= '0;
      end else if (in_xfer) begin
         rnd_q <= rnd_d;
      end
   end

`ifdef ARK_SKID_EN
   ark_skid #(
      .Width(ARK_PAYLOAD_W)
   ) u_skid (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (beat),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_beat)
   );
`else
   logic      out_valid_q;
   ark_beat_t out_q;

   assign in_ready  = rst_n && (out_ready || !out_valid_q);
   assign out_valid = out_valid_q;
   assign out_beat  = out_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (in_ready) begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            out_q <= beat;
         end
      end
   end
`endif

   assign out_data  = out_beat.data;
   assign out_round = out_beat.rnd;
   assign out_last  = out_beat.last;

endmodule
